// File: rtl/sensor_cmd_scheduler.sv
// sensor_cmd_scheduler: host command sequencer for a single DHT11 sensor.
// Assembles 2-byte host frames, runs the sensor, serializes 2-byte replies,
// and interleaves periodic temperature/humidity samples with host traffic.
module sensor_cmd_scheduler #(
    parameter logic [4:0]  SENSOR_ADDR    = 5'd0,
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned BYTE_TIMEOUT   = 5_000_000,
    parameter int unsigned SENSOR_TIMEOUT = 10_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       dht_start,
    input  logic       dht_done,
    input  logic       dht_error,
    input  logic [7:0] dht_temp,
    input  logic [7:0] dht_hum,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       overrun,
    output logic       cont_temp_on,
    output logic       cont_hum_on
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_SENSOR_REQ, S_SENSOR_WAIT,
        S_TX1, S_TX1_WAIT, S_TX2, S_TX2_WAIT
    } state_t;

    // What the current sensor read answers: host query or continuous sample.
    typedef enum logic [2:0] {K_STAT, K_TEMP, K_HUM, K_CTEMP, K_CHUM} kind_t;

    state_t      state;
    kind_t       kind;
    kind_t       tick_kind;
    logic [7:0]  resp1;
    logic [31:0] sens_cnt;
    logic        next_hum;

    logic        have_cmd;
    logic [7:0]  cmd_hold;
    logic [31:0] byte_tmr;
    logic [7:0]  frame_cmd;
    logic [4:0]  frame_addr;
    logic        frame_valid;

    logic [31:0] per_tmr;
    logic        tick_pend;
    logic        cont_any;
    logic        take_frame;
    logic        take_tick;
    logic        dec_cont;
    logic        tick_served;

    assign cont_any    = cont_temp_on | cont_hum_on;
    assign take_frame  = (state == S_IDLE) && frame_valid;
    assign take_tick   = (state == S_IDLE) && !frame_valid && tick_pend && cont_any;
    // A valid 0x03/0x04 is served straight from DECODE as the forced tick.
    assign dec_cont    = (state == S_DECODE) && (frame_cmd == 8'h03 || frame_cmd == 8'h04) &&
                         (frame_addr == SENSOR_ADDR);
    assign tick_served = take_tick | dec_cont;
    // With both modes on, samples alternate starting with temperature.
    assign tick_kind   = (cont_temp_on && (!cont_hum_on || !next_hum)) ? K_CTEMP : K_CHUM;

    // Frame assembler: pairs command/address bytes, drops stale halves and overruns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            have_cmd    <= 1'b0;
            cmd_hold    <= 8'h00;
            byte_tmr    <= '0;
            frame_cmd   <= 8'h00;
            frame_addr  <= 5'd0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (take_frame) frame_valid <= 1'b0;
            if (rx_done) begin
                if (!have_cmd) begin
                    have_cmd <= 1'b1;
                    cmd_hold <= rx_data;
                    byte_tmr <= '0;
                end else begin
                    have_cmd <= 1'b0;
                    if (frame_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        frame_cmd   <= cmd_hold;
                        frame_addr  <= rx_data[4:0];
                        frame_valid <= 1'b1;
                    end
                end
            end else if (have_cmd) begin
                if (byte_tmr == BYTE_TIMEOUT) have_cmd <= 1'b0;
                else                          byte_tmr <= byte_tmr + 32'd1;
            end
        end
    end

    // Period timer: free-runs only while a continuous mode is on; wraps raise tick_pend.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            per_tmr   <= '0;
            tick_pend <= 1'b0;
        end else if (!cont_any) begin
            per_tmr   <= '0;
            tick_pend <= 1'b0;
        end else begin
            if (tick_served) tick_pend <= 1'b0;
            if (per_tmr == PERIOD_CYCLES - 1) begin
                per_tmr   <= '0;
                tick_pend <= 1'b1;
            end else begin
                per_tmr <= per_tmr + 32'd1;
            end
        end
    end

    // Main sequencer: arbitration, decode, sensor handshake and 2-byte reply.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            kind         <= K_STAT;
            resp1        <= 8'h00;
            sens_cnt     <= '0;
            next_hum     <= 1'b0;
            dht_start    <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            busy         <= 1'b0;
            cont_temp_on <= 1'b0;
            cont_hum_on  <= 1'b0;
        end else begin
            dht_start <= 1'b0;
            tx_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take_frame) begin
                        state <= S_DECODE;
                        busy  <= 1'b1;
                    end else if (take_tick) begin
                        state     <= S_SENSOR_REQ;
                        busy      <= 1'b1;
                        kind      <= tick_kind;
                        next_hum  <= (tick_kind == K_CTEMP);
                        dht_start <= 1'b1;
                        sens_cnt  <= '0;
                    end
                end
                S_DECODE: begin
                    sens_cnt <= '0;
                    if (frame_cmd > 8'h06) begin
                        tx_data <= 8'hCF; resp1 <= 8'h00; tx_start <= 1'b1; state <= S_TX1;
                    end else if (frame_addr != SENSOR_ADDR) begin
                        tx_data <= 8'hEF; resp1 <= 8'h00; tx_start <= 1'b1; state <= S_TX1;
                    end else begin
                        case (frame_cmd[2:0])
                            3'd0: begin kind <= K_STAT; dht_start <= 1'b1; state <= S_SENSOR_REQ; end
                            3'd1: begin kind <= K_TEMP; dht_start <= 1'b1; state <= S_SENSOR_REQ; end
                            3'd2: begin kind <= K_HUM;  dht_start <= 1'b1; state <= S_SENSOR_REQ; end
                            3'd3: begin
                                cont_temp_on <= 1'b1; kind <= K_CTEMP; next_hum <= 1'b1;
                                dht_start <= 1'b1; state <= S_SENSOR_REQ;
                            end
                            3'd4: begin
                                cont_hum_on <= 1'b1; kind <= K_CHUM; next_hum <= 1'b0;
                                dht_start <= 1'b1; state <= S_SENSOR_REQ;
                            end
                            3'd5: begin
                                cont_temp_on <= 1'b0;
                                tx_data <= 8'h0A; resp1 <= 8'h00; tx_start <= 1'b1; state <= S_TX1;
                            end
                            default: begin
                                cont_hum_on <= 1'b0;
                                tx_data <= 8'h0B; resp1 <= 8'h00; tx_start <= 1'b1; state <= S_TX1;
                            end
                        endcase
                    end
                end
                S_SENSOR_REQ: state <= S_SENSOR_WAIT;
                S_SENSOR_WAIT: begin
                    // dht_done on the timeout clock still counts as a completed read.
                    if (dht_done) begin
                        tx_start <= 1'b1;
                        state    <= S_TX1;
                        if (dht_error) begin
                            tx_data <= 8'h1F; resp1 <= 8'h00;
                        end else begin
                            case (kind)
                                K_STAT:  begin tx_data <= 8'h07; resp1 <= 8'h00;     end
                                K_TEMP:  begin tx_data <= 8'h09; resp1 <= dht_temp; end
                                K_HUM:   begin tx_data <= 8'h08; resp1 <= dht_hum;  end
                                K_CTEMP: begin tx_data <= 8'h0D; resp1 <= dht_temp; end
                                default: begin tx_data <= 8'h0E; resp1 <= dht_hum;  end
                            endcase
                        end
                    end else if (sens_cnt == SENSOR_TIMEOUT) begin
                        tx_data <= 8'h1F; resp1 <= 8'h00; tx_start <= 1'b1; state <= S_TX1;
                    end else begin
                        sens_cnt <= sens_cnt + 32'd1;
                    end
                end
                S_TX1: state <= S_TX1_WAIT;
                S_TX1_WAIT: begin
                    if (tx_done) begin
                        tx_data  <= resp1;
                        tx_start <= 1'b1;
                        state    <= S_TX2;
                    end
                end
                S_TX2: state <= S_TX2_WAIT;
                S_TX2_WAIT: begin
                    if (tx_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_cmd_scheduler.sv
// Bench for sensor_cmd_scheduler: table of single-frame transactions plus
// hand-written sequences for timeouts, overrun, continuous mode and reset.
module tb_sensor_cmd_scheduler;

    localparam int PER = 100;
    localparam int BTO = 50;
    localparam int STO = 200;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       dht_start;
    logic       dht_done = 1'b0;
    logic       dht_error = 1'b0;
    logic [7:0] dht_temp = 8'h00;
    logic [7:0] dht_hum = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       busy;
    logic       overrun;
    logic       cont_temp_on;
    logic       cont_hum_on;

    always #5 clock = ~clock;

    sensor_cmd_scheduler #(
        .SENSOR_ADDR(5'd0), .PERIOD_CYCLES(PER), .BYTE_TIMEOUT(BTO), .SENSOR_TIMEOUT(STO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .rx_done(rx_done), .rx_data(rx_data),
        .dht_start(dht_start), .dht_done(dht_done), .dht_error(dht_error),
        .dht_temp(dht_temp), .dht_hum(dht_hum), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .overrun(overrun),
        .cont_temp_on(cont_temp_on), .cont_hum_on(cont_hum_on)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // sensor / uart stand-in configuration (written by the test sequence)
    int       dht_delay = 4;
    bit       dht_resp = 1'b1;
    bit       dht_err_cfg = 1'b0;
    logic [7:0] t_cfg = 8'h00;
    logic [7:0] h_cfg = 8'h00;

    // observations (written only by the responder)
    int         nstart = 0;
    int         last_dht_cyc = 0;
    logic [7:0] txq[$];
    int         tx_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Sensor and UART transmitter models: answer dht_start / tx_start, log every byte.
    int dcnt = 0;
    int tcnt = 0;
    always @(negedge clock) begin
        dht_done  = 1'b0;
        dht_error = 1'b0;
        tx_done   = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0 && dht_resp) begin
                dht_done = 1'b1; dht_error = dht_err_cfg; dht_temp = t_cfg; dht_hum = h_cfg;
            end
        end
        if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) tx_done = 1'b1;
        end
        if (dht_start) begin nstart++; last_dht_cyc = cyc; dcnt = dht_delay; end
        if (tx_start) begin txq.push_back(tx_data); tx_cyc.push_back(cyc); tcnt = 3; end
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        bit         resp;
        bit         err;
        logic [7:0] t;
        logic [7:0] h;
        logic [7:0] e0;
        logic [7:0] e1;
        int         ens;
        bit         to;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock); rx_data = b; rx_done = 1'b1;
        @(negedge clock); rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a);
        send_byte(c);
        send_byte(a);
    endtask

    task automatic wait_bytes(input int n, input string name);
        int k = 0;
        while (txq.size() < n && k < 3000) begin @(negedge clock); k++; end
        checks++;
        if (txq.size() < n) begin
            errors++;
            $display("FAIL %s: timed out with %0d bytes sent, expected %0d", name, txq.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 500) begin @(negedge clock); k++; end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [7:0] qb(input int i);
        return (i < txq.size()) ? txq[i] : 8'h00;
    endfunction

    function automatic int qc(input int i);
        return (i < tx_cyc.size()) ? tx_cyc[i] : 0;
    endfunction

    // Expect one 2-byte reply starting at txq index q.
    task automatic expect_resp(input int q, input logic [7:0] e0, input logic [7:0] e1, input string name);
        wait_bytes(q + 2, {name, " wait"});
        chk({name, " byte1"}, {24'd0, qb(q)}, {24'd0, e0});
        chk({name, " byte2"}, {24'd0, qb(q + 1)}, {24'd0, e1});
    endtask

    initial begin
        int s0, q0, tq;
        string nm;

        //          cmd    addr   rsp err  temp   hum    b1     b2   starts to
        vecs[0]  = '{8'h01, 8'h00, 1, 0, 8'h19, 8'h00, 8'h09, 8'h19, 1, 0};
        vecs[1]  = '{8'h02, 8'h03, 1, 0, 8'h00, 8'h00, 8'hEF, 8'h00, 0, 0};
        vecs[2]  = '{8'h07, 8'h00, 1, 0, 8'h00, 8'h00, 8'hCF, 8'h00, 0, 0};
        vecs[3]  = '{8'h02, 8'h00, 1, 0, 8'h00, 8'h2D, 8'h08, 8'h2D, 1, 0};
        vecs[4]  = '{8'h00, 8'h00, 1, 0, 8'h11, 8'h22, 8'h07, 8'h00, 1, 0};
        vecs[5]  = '{8'h00, 8'h00, 1, 1, 8'h11, 8'h22, 8'h1F, 8'h00, 1, 0};
        vecs[6]  = '{8'h01, 8'h00, 1, 1, 8'h55, 8'h22, 8'h1F, 8'h00, 1, 0};
        vecs[7]  = '{8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h1F, 8'h00, 1, 1};
        vecs[8]  = '{8'h05, 8'h00, 1, 0, 8'h00, 8'h00, 8'h0A, 8'h00, 0, 0};
        vecs[9]  = '{8'h06, 8'h00, 1, 0, 8'h00, 8'h00, 8'h0B, 8'h00, 0, 0};
        vecs[10] = '{8'hFF, 8'h1F, 1, 0, 8'h00, 8'h00, 8'hCF, 8'h00, 0, 0};
        vecs[11] = '{8'h03, 8'h05, 1, 0, 8'h00, 8'h00, 8'hEF, 8'h00, 0, 0};
        vecs[12] = '{8'h02, 8'h20, 1, 0, 8'h00, 8'h41, 8'h08, 8'h41, 1, 0};
        vecs[13] = '{8'h01, 8'h00, 1, 0, 8'hFF, 8'h00, 8'h09, 8'hFF, 1, 0};

        // reset state
        repeat (3) @(negedge clock);
        chk("rst dht_start", {31'd0, dht_start}, 32'd0);
        chk("rst tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst overrun", {31'd0, overrun}, 32'd0);
        chk("rst cont flags", {30'd0, cont_temp_on, cont_hum_on}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // single-frame transactions
        for (int i = 0; i < NV; i++) begin
            dht_resp = vecs[i].resp; dht_err_cfg = vecs[i].err;
            t_cfg = vecs[i].t; h_cfg = vecs[i].h;
            s0 = nstart; q0 = txq.size();
            nm = $sformatf("vec%0d", i);
            send_frame(vecs[i].cmd, vecs[i].addr);
            expect_resp(q0, vecs[i].e0, vecs[i].e1, nm);
            wait_idle({nm, " idle"});
            chk({nm, " dht_start count"}, nstart - s0, vecs[i].ens);
            chk({nm, " cont flags"}, {30'd0, cont_temp_on, cont_hum_on}, 32'd0);
            if (vecs[i].to) chk({nm, " timeout latency"}, qc(q0) - last_dht_cyc, STO + 2);
        end
        dht_resp = 1'b1; dht_err_cfg = 1'b0;

        // lone command byte expires; the next pair is a clean humidity request
        h_cfg = 8'h37; q0 = txq.size();
        send_byte(8'h01);
        repeat (BTO + 10) @(negedge clock);
        send_frame(8'h02, 8'h00);
        expect_resp(q0, 8'h08, 8'h37, "byte timeout");
        wait_idle("byte timeout idle");

        // three frames while the first is in service: the third is dropped
        dht_delay = 150; t_cfg = 8'h21; q0 = txq.size();
        send_frame(8'h00, 8'h00);
        send_frame(8'h01, 8'h00);
        send_frame(8'h02, 8'h00);
        expect_resp(q0, 8'h07, 8'h00, "ovr first");
        expect_resp(q0 + 2, 8'h09, 8'h21, "ovr second");
        wait_idle("ovr idle");
        repeat (200) @(negedge clock);
        chk("ovr no third reply", txq.size(), q0 + 4);
        chk("ovr sticky", {31'd0, overrun}, 32'd1);
        dht_delay = 4;

        // continuous mode: acks are first samples, then alternation every PER clocks
        t_cfg = 8'h1A; h_cfg = 8'h30; q0 = txq.size();
        send_frame(8'h03, 8'h00);
        expect_resp(q0, 8'h0D, 8'h1A, "cont temp ack");
        chk("cont temp flag", {30'd0, cont_temp_on, cont_hum_on}, 32'd2);
        send_frame(8'h04, 8'h00);
        expect_resp(q0 + 2, 8'h0E, 8'h30, "cont hum ack");
        chk("cont both flags", {30'd0, cont_temp_on, cont_hum_on}, 32'd3);
        expect_resp(q0 + 4, 8'h0D, 8'h1A, "tick temp");
        expect_resp(q0 + 6, 8'h0E, 8'h30, "tick hum");
        chk("tick period", qc(q0 + 6) - qc(q0 + 4), PER);
        send_frame(8'h05, 8'h00);
        expect_resp(q0 + 8, 8'h0A, 8'h00, "cont temp off");
        chk("hum only flags", {30'd0, cont_temp_on, cont_hum_on}, 32'd1);
        expect_resp(q0 + 10, 8'h0E, 8'h30, "hum only tick1");
        expect_resp(q0 + 12, 8'h0E, 8'h30, "hum only tick2");

        // pending frame and pending tick meet in IDLE: host frame goes first
        dht_delay = 150; t_cfg = 8'h44; h_cfg = 8'h31; q0 = txq.size();
        send_frame(8'h00, 8'h00);
        send_frame(8'h01, 8'h00);
        expect_resp(q0, 8'h07, 8'h00, "arb status");
        expect_resp(q0 + 2, 8'h09, 8'h44, "arb host first");
        expect_resp(q0 + 4, 8'h0E, 8'h31, "arb tick next");

        // reset while the second reply byte is in flight
        tq = txq.size();
        wait_bytes(tq + 2, "reset wait tx2");
        @(negedge clock);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset tx_start", {31'd0, tx_start}, 32'd0);
        chk("reset tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset cont flags", {30'd0, cont_temp_on, cont_hum_on}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        dht_delay = 4;
        s0 = nstart; q0 = txq.size();
        repeat (250) @(negedge clock);
        chk("post-reset quiet tx", txq.size(), q0);
        chk("post-reset quiet dht", nstart, s0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
